// File: rtl/rom_pkg.sv
// Shared types and sizing for the ROM burst reader and its output FIFO.
package rom_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/rom_stream_fifo.sv
// Two-entry synchronous FIFO buffering ROM words ahead of the stream port.
module rom_stream_fifo
  import rom_pkg::*;
#(
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_pop,
  output logic [FIFO_CNT_W-1:0] o_count,
  output logic [DATA_W-1:0]     o_head
);

  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic                  r_wr;
  logic                  r_rd;
  logic [FIFO_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) begin
        r_rd <= ~r_rd;
      end
      if (i_push && !i_pop) begin
        r_cnt <= r_cnt + FIFO_CNT_W'(1);
      end else if (i_pop && !i_push) begin
        r_cnt <= r_cnt - FIFO_CNT_W'(1);
      end
    end
  end

  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/rom_burst_reader.sv
// Reads a wrapping burst from a 1-cycle-latency ROM and streams it out
// on valid/ready with last-marking, using credits to bound FIFO occupancy.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam logic [ADDR_W:0] C_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_ptr;
  logic [ADDR_W:0]       r_len;
  logic [ADDR_W:0]       r_issued;
  logic [ADDR_W:0]       r_words;
  logic                  r_inflight;
  logic [FIFO_CNT_W-1:0] w_cnt;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_hs;
  logic [2:0]            w_used;
  logic [2:0]            w_cap;

  rom_stream_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (rom_data),
    .i_pop   (w_pop),
    .o_count (w_cnt),
    .o_head  (m_data)
  );

  assign m_valid   = (w_cnt != '0);
  assign w_pop     = m_valid & m_ready;
  assign m_last    = m_valid && ((r_words + C_ONE) == r_len);
  assign w_last_hs = w_pop & m_last;

  // A slot is free if occupancy plus the word in flight stays below
  // depth, counting a slot vacated by this cycle's pop.
  assign w_used  = 3'(w_cnt) + 3'(r_inflight);
  assign w_cap   = 3'(FIFO_DEPTH) + 3'(w_pop);
  assign w_issue = (r_state == RUN) && (r_issued < r_len) && (w_used < w_cap);

  assign rom_en   = w_issue;
  assign rom_addr = r_ptr;
  assign busy     = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (w_issue && (r_issued == (r_len - C_ONE))) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_hs && !r_inflight && (w_cnt == FIFO_CNT_W'(1))) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_words    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if ((r_state == IDLE) && start) begin
        r_ptr    <= start_addr;
        r_len    <= len;
        r_issued <= '0;
        r_words  <= '0;
      end
      if (w_issue) begin
        r_ptr    <= r_ptr + ADDR_W'(1);
        r_issued <= r_issued + C_ONE;
      end
      if (w_pop) begin
        r_words <= r_words + C_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed and random bursts against a
// ROM-table reference model with cycle-accurate timing checks.
module tb_rom_burst_reader;

  localparam logic [3:0] ROM_C [16] = '{
    4'd2, 4'd2, 4'd14, 4'd2, 4'd4, 4'd10, 4'd12, 4'd0,
    4'd10, 4'd2, 4'd14, 4'd2, 4'd4, 4'd10, 4'd12, 4'd0
  };

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic       busy;
  logic       done;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       m_last;

  rom_burst_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_data <= rom_en ? ROM_C[rom_addr] : 'x;
  end

  int n_cmp;
  int n_bad;

  int         cyc;
  logic [3:0] got_q [$];
  logic       lastf_q [$];
  logic [3:0] addr_q [$];
  int n_en, n_done, n_busy, n_mv, en_lt10;
  int en_first, en_last, mv_first, last_cyc, done_cyc;
  int busy_first, busy_last, d9;
  logic       p_stall;
  logic [3:0] p_data;
  logic       p_last;

  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0;
    got_q.delete();
    lastf_q.delete();
    addr_q.delete();
    n_en = 0; n_done = 0; n_busy = 0; n_mv = 0; en_lt10 = 0;
    en_first = -1; en_last = -1; mv_first = -1; last_cyc = -1;
    done_cyc = -1; busy_first = -1; busy_last = -1; d9 = -1;
    p_stall = 1'b0;
  endtask

  task automatic tick();
    #1;
    if (p_stall) begin
      check("hold_valid", int'(m_valid), 1);
      check("hold_data", int'(m_data), int'(p_data));
      check("hold_last", int'(m_last), int'(p_last));
    end
    if (rom_en) begin
      n_en++;
      if (cyc < 10) en_lt10++;
      addr_q.push_back(rom_addr);
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (m_valid) begin
      n_mv++;
      if (mv_first < 0) mv_first = cyc;
      if (m_last) last_cyc = cyc;
      if (cyc == 9) d9 = int'(m_data);
      if (m_ready) begin
        got_q.push_back(m_data);
        lastf_q.push_back(m_last);
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) begin
      n_busy++;
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    p_stall = m_valid && !m_ready;
    p_data  = m_data;
    p_last  = m_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: a burst of ln words reads addresses (sa+i) mod 16 in order.
  task automatic burst(int sa, int ln, int pct, int hold, bit dup);
    clr();
    start      = 1'b1;
    start_addr = 4'(sa);
    len        = 5'(ln);
    m_ready    = (hold > 0) ? 1'b0 : ($urandom_range(99) < pct);
    tick();
    start = 1'b0;
    for (int k = 0; k < 300 && n_done == 0; k++) begin
      start = dup && (cyc == 3);
      if (start) begin
        start_addr = ~4'(sa);
        len        = 5'd7;
      end
      m_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      tick();
    end
    start = 1'b0;
    if (n_done == 0) check("timeout", 0, 1);
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("n_words", got_q.size(), ln);
    check("n_rom_en", n_en, ln);
    check("n_done", n_done, 1);
    for (int i = 0; i < ln; i++) begin
      if (i < got_q.size()) begin
        check("word", int'(got_q[i]), int'(ROM_C[(sa + i) % 16]));
        check("last", int'(lastf_q[i]), int'(i == ln - 1));
      end
      if (i < addr_q.size()) begin
        check("addr", int'(addr_q[i]), (sa + i) % 16);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr();
    rst_n      = 1'b0;
    start      = 1'b1;
    start_addr = 4'd3;
    len        = 5'd5;
    m_ready    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rom_en", int'(rom_en), 0);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_last", int'(m_last), 0);
    end
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_m_data", int'(m_data), 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    burst(0, 16, 100, 0, 1'b0);
    check("full_en_first", en_first, 1);
    check("full_en_last", en_last, 16);
    check("full_mv_first", mv_first, 3);
    check("full_n_mv", n_mv, 16);
    check("full_last_cyc", last_cyc, 18);
    check("full_done_cyc", done_cyc, 19);
    check("full_busy_first", busy_first, 1);
    check("full_busy_last", busy_last, 19);
    check("full_n_busy", n_busy, 19);

    burst(14, 4, 100, 0, 1'b0);

    burst(4, 6, 100, 10, 1'b0);
    check("bp_en_before10", en_lt10, 2);
    check("bp_data_c9", d9, 4);

    burst(9, 0, 100, 0, 1'b0);
    check("len0_done_cyc", done_cyc, 1);
    check("len0_mv_first", mv_first, -1);

    burst(2, 5, 100, 0, 1'b1);

    clr();
    start      = 1'b1;
    start_addr = 4'd0;
    len        = 5'd16;
    m_ready    = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_rom_en", int'(rom_en), 0);
    check("mid_m_valid", int'(m_valid), 0);
    check("mid_m_last", int'(m_last), 0);
    check("mid_rom_addr", int'(rom_addr), 0);
    check("mid_m_data", int'(m_data), 0);
    for (int k = 0; k < 4; k++) tick();
    check("mid_no_done", n_done, 0);
    check("mid_no_valid", int'(m_valid), 0);
    burst(8, 2, 100, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      burst(int'($urandom_range(15)), int'($urandom_range(16)),
            int'($urandom_range(100, 20)), int'($urandom_range(4)),
            1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
